simd_alu_pipe: RTL and testbench

Pipelined, lane-parallel successor to the scalar processor ALU for the audio FIR datapath. It applies one opcode to `LANES` packed signed fixed-point lanes per beat and saturates results instead of wrapping. It adds a per-lane multiply-accumulate with persistent accumulators and accepts/delivers beats through valid/ready handshakes. It sits between the vector register file read port and the writeback stage of the SIMD core.

---
 rtl/simd_alu_pkg.sv | 23 ++
 rtl/simd_alu_lane.sv | 112 +++++++++++
 rtl/simd_alu_pipe.sv | 88 ++++++++
 tb/tb_simd_alu_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// simd_alu_pkg: opcode encoding and flag bit positions shared by the SIMD ALU pipeline.
// Revision 1.0
`default_nettype none

package simd_alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD    = 4'd0,
      OP_SUB    = 4'd1,
      OP_MUL    = 4'd2,
      OP_SRA    = 4'd3,
      OP_MAC    = 4'd4,
      OP_CLRACC = 4'd5
   } alu_op_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

endpackage

`default_nettype wire

// File: rtl/simd_alu_lane.sv
// simd_alu_lane: one lane's operand/product stage, saturating result stage and accumulator.
// Revision 1.0
`default_nettype none

module simd_alu_lane
   import simd_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int FRAC  = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_s1,
   input  logic             load_s2,
   input  alu_op_e          op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] res,
   output logic             sat,
   output logic             carry,
   output logic             zero
);

   localparam int XW  = 2*WIDTH + 1;
   localparam int SHW = $clog2(WIDTH);
   localparam logic signed [XW-1:0] C_MAX = {{(XW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [XW-1:0] C_MIN = {{(XW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   logic signed [WIDTH-1:0]   a_q, b_q, acc_q, res_c;
   logic signed [2*WIDTH-1:0] prod_q, prod_sh;
   logic signed [XW-1:0]      a_x, b_x, acc_x, prod_x, wide;
   logic [WIDTH:0]            usum;
   logic                      use_sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         prod_q <= '0;
      end else if (load_s1) begin
         a_q    <= a;
         b_q    <= b;
         prod_q <= $signed(a) * $signed(b);
      end
   end

   assign prod_sh = prod_q >>> FRAC;
   assign prod_x  = {prod_sh[2*WIDTH-1], prod_sh};
   assign a_x     = {{(XW-WIDTH){a_q[WIDTH-1]}}, a_q};
   assign b_x     = {{(XW-WIDTH){b_q[WIDTH-1]}}, b_q};
   assign acc_x   = {{(XW-WIDTH){acc_q[WIDTH-1]}}, acc_q};
   assign usum    = {1'b0, a_q} + {1'b0, b_q};

   always_comb begin
      wide    = '0;
      use_sat = 1'b0;
      carry   = 1'b0;
      sat     = 1'b0;
      res_c   = '0;
      case (op)
         OP_ADD: begin
            wide    = a_x + b_x;
            use_sat = 1'b1;
            carry   = usum[WIDTH];
         end
         OP_SUB: begin
            wide    = a_x - b_x;
            use_sat = 1'b1;
            carry   = ($unsigned(a_q) < $unsigned(b_q));
         end
         OP_MUL: begin
            wide    = prod_x;
            use_sat = 1'b1;
         end
         OP_MAC: begin
            wide    = acc_x + prod_x;
            use_sat = 1'b1;
         end
         OP_SRA:  res_c = a_q >>> b_q[SHW-1:0];
         default: res_c = '0;
      endcase
      if (use_sat) begin
         if (wide > C_MAX) begin
            res_c = C_MAX[WIDTH-1:0];
            sat   = 1'b1;
         end else if (wide < C_MIN) begin
            res_c = C_MIN[WIDTH-1:0];
            sat   = 1'b1;
         end else begin
            res_c = wide[WIDTH-1:0];
         end
      end
   end

   assign zero = (res_c == '0);

   // The accumulator advances in the same edge that moves the beat into the output register,
   // so a following MAC already sees the updated value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
         res   <= '0;
      end else if (load_s2) begin
         res <= res_c;
         if (op == OP_CLRACC)   acc_q <= '0;
         else if (op == OP_MAC) acc_q <= res_c;
      end
   end

endmodule

`default_nettype wire

// File: rtl/simd_alu_pipe.sv
// simd_alu_pipe: two-stage, lane-parallel saturating ALU with MAC accumulators and valid/ready handshakes.
// Revision 1.0
`default_nettype none

module simd_alu_pipe
   import simd_alu_pkg::*;
#(
   parameter int LANES = 4,
   parameter int WIDTH = 16,
   parameter int FRAC  = 15
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             op,
   input  logic [LANES*WIDTH-1:0] a,
   input  logic [LANES*WIDTH-1:0] b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*WIDTH-1:0] result,
   output logic [3:0]             flags
);

   logic             s1_valid, adv, load_s1, load_s2, op_known;
   alu_op_e          s1_op;
   logic [LANES-1:0] lane_sat, lane_carry, lane_zero;
   logic             z_q, c_q, v_q;

   assign adv      = !out_valid || out_ready;
   assign in_ready = adv || !s1_valid;
   assign load_s1  = in_valid && in_ready;
   assign load_s2  = adv && s1_valid;
   assign op_known = (s1_op <= OP_CLRACC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_op     <= OP_ADD;
         out_valid <= 1'b0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         v_q       <= 1'b0;
      end else begin
         if (in_ready) s1_valid <= in_valid;
         if (load_s1)  s1_op    <= alu_op_e'(op);
         if (adv)      out_valid <= s1_valid;
         // Unknown opcodes still yield a beat but report no flags at all.
         if (load_s2) begin
            z_q <= op_known && (&lane_zero);
            c_q <= op_known && (|lane_carry);
            v_q <= op_known && (|lane_sat);
         end
      end
   end

   always_comb begin
      flags         = '0;
      flags[FLAG_N] = result[WIDTH-1];
      flags[FLAG_Z] = z_q;
      flags[FLAG_C] = c_q;
      flags[FLAG_V] = v_q;
   end

   generate
      for (genvar i = 0; i < LANES; i++) begin : g_lane
         simd_alu_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC)
         ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_s1 (load_s1),
            .load_s2 (load_s2),
            .op      (s1_op),
            .a       (a[i*WIDTH +: WIDTH]),
            .b       (b[i*WIDTH +: WIDTH]),
            .res     (result[i*WIDTH +: WIDTH]),
            .sat     (lane_sat[i]),
            .carry   (lane_carry[i]),
            .zero    (lane_zero[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_simd_alu_pipe.sv
// tb_simd_alu_pipe: directed self-checking bench for simd_alu_pipe (LANES=4, WIDTH=16, FRAC=15).
// Revision 1.0
`default_nettype none

module tb_simd_alu_pipe;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  op;
   logic [63:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] result;
   logic [3:0]  flags;

   int errors = 0;
   int checks = 0;

   simd_alu_pipe #(.LANES(4), .WIDTH(16), .FRAC(15)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] rep(input logic [15:0] v);
      return {4{v}};
   endfunction

   function automatic logic [63:0] pk(input logic [15:0] l3, l2, l1, l0);
      return {l3, l2, l1, l0};
   endfunction

   // Issue one beat with the consumer always ready and return the beat that emerges.
   task automatic run_one(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv,
                          output logic [63:0] r, output logic [3:0] f);
      int n;
      @(negedge clk);
      op = o; a = av; b = bv; in_valid = 1'b1; out_ready = 1'b1;
      n = 0;
      while (!in_ready && n < 10) begin @(negedge clk); n++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 10) begin @(negedge clk); n++; end
      checks++;
      if (!out_valid) begin
         errors++;
         $display("FAIL timeout op=%h: out_valid=%b required 1", o, out_valid);
      end
      r = result; f = flags;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
      #12;
      checks++;
      if (out_valid !== 1'b0 || result !== 64'h0 || flags !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset: out_valid=%b result=%h flags=%b in_ready=%b required 0/0/0/1",
                  out_valid, result, flags, in_ready);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_add();
      logic [63:0] r; logic [3:0] f;
      run_one(4'h0, rep(16'h0002), rep(16'h0004), r, f);
      checks++;
      if (r !== rep(16'h0006) || f !== 4'b0000) begin
         errors++; $display("FAIL add_basic: got %h/%b required %h/0000", r, f, rep(16'h0006));
      end
      run_one(4'h0, pk(16'h0001, 16'h0001, 16'h0001, 16'h7000),
                    pk(16'h0001, 16'h0001, 16'h0001, 16'h7000), r, f);
      checks++;
      if (r !== pk(16'h0002, 16'h0002, 16'h0002, 16'h7FFF) || f !== 4'b0001) begin
         errors++; $display("FAIL add_sat: got %h/%b required 0002000200027fff/0001", r, f);
      end
      run_one(4'h0, rep(16'hFFFF), rep(16'h0001), r, f);
      checks++;
      if (r !== 64'h0 || f !== 4'b0110) begin
         errors++; $display("FAIL add_carry: got %h/%b required 0/0110", r, f);
      end
   endtask

   task automatic test_sub();
      logic [63:0] r; logic [3:0] f;
      run_one(4'h1, rep(16'h0006), rep(16'h0002), r, f);
      checks++;
      if (r !== rep(16'h0004) || f !== 4'b0000) begin
         errors++; $display("FAIL sub_basic: got %h/%b required %h/0000", r, f, rep(16'h0004));
      end
      run_one(4'h1, pk(16'h0005, 16'h0005, 16'h0005, 16'h8000), rep(16'h0001), r, f);
      checks++;
      if (r !== pk(16'h0004, 16'h0004, 16'h0004, 16'h8000) || f !== 4'b1001) begin
         errors++; $display("FAIL sub_sat: got %h/%b required 0004000400048000/1001", r, f);
      end
      run_one(4'h1, rep(16'h0003), rep(16'h0003), r, f);
      checks++;
      if (r !== 64'h0 || f !== 4'b0100) begin
         errors++; $display("FAIL sub_zero: got %h/%b required 0/0100", r, f);
      end
      run_one(4'h1, rep(16'h0001), rep(16'h0002), r, f);
      checks++;
      if (r !== rep(16'hFFFF) || f !== 4'b1010) begin
         errors++; $display("FAIL sub_borrow: got %h/%b required %h/1010", r, f, rep(16'hFFFF));
      end
   endtask

   task automatic test_mul_sra_nop();
      logic [63:0] r; logic [3:0] f;
      run_one(4'h2, rep(16'h4000), rep(16'h4000), r, f);
      checks++;
      if (r !== rep(16'h2000) || f !== 4'b0000) begin
         errors++; $display("FAIL mul_half: got %h/%b required %h/0000", r, f, rep(16'h2000));
      end
      run_one(4'h2, rep(16'h8000), rep(16'h8000), r, f);
      checks++;
      if (r !== rep(16'h7FFF) || f !== 4'b0001) begin
         errors++; $display("FAIL mul_sat: got %h/%b required %h/0001", r, f, rep(16'h7FFF));
      end
      run_one(4'h2, pk(16'h0000, 16'h0000, 16'hFFFF, 16'hC000),
                    pk(16'h0000, 16'h0000, 16'h0001, 16'h4000), r, f);
      checks++;
      if (r !== pk(16'h0000, 16'h0000, 16'hFFFF, 16'hE000) || f !== 4'b1000) begin
         errors++; $display("FAIL mul_neg: got %h/%b required 00000000ffffe000/1000", r, f);
      end
      run_one(4'h3, rep(16'h0008), rep(16'h0002), r, f);
      checks++;
      if (r !== rep(16'h0002) || f !== 4'b0000) begin
         errors++; $display("FAIL sra_pos: got %h/%b required %h/0000", r, f, rep(16'h0002));
      end
      run_one(4'h3, pk(16'h0100, 16'h0100, 16'h0100, 16'hFFF0),
                    pk(16'h0014, 16'h0014, 16'h0014, 16'h0002), r, f);
      checks++;
      if (r !== pk(16'h0010, 16'h0010, 16'h0010, 16'hFFFC) || f !== 4'b1000) begin
         errors++; $display("FAIL sra_neg: got %h/%b required 001000100010fffc/1000", r, f);
      end
      run_one(4'hF, rep(16'h0005), rep(16'h0005), r, f);
      checks++;
      if (r !== 64'h0 || f !== 4'b0000) begin
         errors++; $display("FAIL nop: got %h/%b required 0/0000", r, f);
      end
   endtask

   task automatic test_mac();
      logic [63:0] got [4];
      logic [3:0]  gf  [4];
      int          cyc [4];
      logic [63:0] exp_r [4];
      logic [3:0]  exp_f [4];
      logic [63:0] r; logic [3:0] f;
      int n = 0;
      exp_r[0] = rep(16'h2000); exp_r[1] = rep(16'h4000);
      exp_r[2] = rep(16'h6000); exp_r[3] = rep(16'h7FFF);
      exp_f[0] = 4'b0000; exp_f[1] = 4'b0000; exp_f[2] = 4'b0000; exp_f[3] = 4'b0001;
      for (int i = 0; i < 4; i++) begin got[i] = 'x; gf[i] = 'x; cyc[i] = 0; end
      out_ready = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (out_valid && n < 4) begin got[n] = result; gf[n] = flags; cyc[n] = c; n++; end
         if (c < 4) begin in_valid = 1'b1; op = 4'h4; a = rep(16'h4000); b = rep(16'h4000); end
         else in_valid = 1'b0;
      end
      checks++;
      if (n != 4 || cyc[3] - cyc[0] != 3) begin
         errors++; $display("FAIL mac_stream: beats=%0d span=%0d required 4/3", n, cyc[3] - cyc[0]);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (got[i] !== exp_r[i] || gf[i] !== exp_f[i]) begin
            errors++;
            $display("FAIL mac_beat%0d: got %h/%b required %h/%b", i, got[i], gf[i], exp_r[i], exp_f[i]);
         end
      end
      run_one(4'h5, rep(16'h1234), rep(16'h1234), r, f);
      checks++;
      if (r !== 64'h0) begin
         errors++; $display("FAIL clracc: got %h required 0", r);
      end
      run_one(4'h4, rep(16'h4000), rep(16'h4000), r, f);
      checks++;
      if (r !== rep(16'h2000) || f !== 4'b0000) begin
         errors++; $display("FAIL mac_after_clr: got %h/%b required %h/0000", r, f, rep(16'h2000));
      end
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; op = 4'h0; a = rep(16'h0001); b = rep(16'h0001);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept1: in_ready=%b required 1", in_ready); end
      @(negedge clk);
      a = rep(16'h0002); b = rep(16'h0002);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_accept2: in_ready=%b required 1", in_ready); end
      @(negedge clk);
      a = rep(16'h0003); b = rep(16'h0003);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== rep(16'h0002)) begin
         errors++;
         $display("FAIL bp_stall: in_ready=%b out_valid=%b result=%h required 0/1/%h",
                  in_ready, out_valid, result, rep(16'h0002));
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || result !== rep(16'h0002)) begin
         errors++; $display("FAIL bp_hold: in_ready=%b result=%h required 0/%h", in_ready, result, rep(16'h0002));
      end
      out_ready = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: in_ready=%b required 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1 || result !== rep(16'h0004)) begin
         errors++; $display("FAIL bp_order2: out_valid=%b result=%h required 1/%h", out_valid, result, rep(16'h0004));
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || result !== rep(16'h0006)) begin
         errors++; $display("FAIL bp_order3: out_valid=%b result=%h required 1/%h", out_valid, result, rep(16'h0006));
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: out_valid=%b required 0", out_valid); end
   endtask

   task automatic test_reset_mid_mac();
      logic [63:0] r; logic [3:0] f;
      @(negedge clk);
      out_ready = 1'b1; in_valid = 1'b1; op = 4'h4; a = rep(16'h4000); b = rep(16'h4000);
      @(negedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || result !== 64'h0 || flags !== 4'h0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: out_valid=%b result=%h flags=%b in_ready=%b required 0/0/0/1",
                  out_valid, result, flags, in_ready);
      end
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      run_one(4'h4, rep(16'h4000), rep(16'h4000), r, f);
      checks++;
      if (r !== rep(16'h2000)) begin
         errors++; $display("FAIL mac_after_reset: got %h required %h", r, rep(16'h2000));
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_mul_sra_nop();
      test_mac();
      test_backpressure();
      test_reset_mid_mac();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
